// File: rtl/tagged_array_reader_pkg.sv
// Shared types and constants for the tagged array reader.
// The SWEEP state exists only when TAGGED_READER_SWEEP_EN is defined.
package tagged_array_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int WIDTH_DEF = 3;
    localparam int IDXW_DEF  = 4;

    localparam logic TAG_L = 1'b0;
    localparam logic TAG_H = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
`ifdef TAGGED_READER_SWEEP_EN
        ,
        SWEEP  = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/tagged_array_reader_if.sv
// Request/response bus plus writer-side array view for the tagged array reader.
// Sweep signals are present only when TAGGED_READER_SWEEP_EN is defined.
interface tagged_array_reader_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 3,
    parameter int IDXW  = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic [IDXW-1:0]        req_idx;
    logic [DEPTH-1:0]       tags_vec;
    logic [DEPTH*WIDTH-1:0] data_vec;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_data;
    logic                   rsp_masked;
`ifdef TAGGED_READER_SWEEP_EN
    logic                   sweep_start;
    logic                   sweep_done;
    logic [IDXW:0]          sweep_high_cnt;
`endif

    modport master (
        output req_valid, req_idx, tags_vec, data_vec, rsp_ready,
`ifdef TAGGED_READER_SWEEP_EN
        output sweep_start,
        input  sweep_done, sweep_high_cnt,
`endif
        input  req_ready, rsp_valid, rsp_data, rsp_masked
    );

    modport slave (
        input  req_valid, req_idx, tags_vec, data_vec, rsp_ready,
`ifdef TAGGED_READER_SWEEP_EN
        input  sweep_start,
        output sweep_done, sweep_high_cnt,
`endif
        output req_ready, rsp_valid, rsp_data, rsp_masked
    );

endinterface

// File: rtl/tagged_array_reader_tag_mask_sel.sv
// Combinational entry select with masking: an H-tagged entry yields zero data,
// so high data never leaves this block toward any register or output.
import tagged_array_pkg::*;

module tag_mask_sel #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDXW  = IDXW_DEF
) (
    input  logic [IDXW-1:0]        i_idx,
    input  logic [DEPTH-1:0]       i_tags_vec,
    input  logic [DEPTH*WIDTH-1:0] i_data_vec,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_masked
);
    logic             w_tag;
    logic [WIDTH-1:0] w_entry;

    assign w_tag    = i_tags_vec[i_idx];
    assign w_entry  = i_data_vec[i_idx*WIDTH +: WIDTH];
    assign o_masked = (w_tag == TAG_H);
    assign o_data   = (w_tag == TAG_L) ? w_entry : '0;

endmodule

// File: rtl/tagged_array_reader.sv
// Tagged array reader: IDLE -> LOOKUP (atomic tag+data snapshot) -> RESP.
// Optional tag sweep enabled by TAGGED_READER_SWEEP_EN.
import tagged_array_pkg::*;

module tagged_array_reader #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDXW  = IDXW_DEF
) (
    input logic                  clk,
    input logic                  rst,
    tagged_array_reader_if.slave io_bus
);
    state_t           r_state;
    state_t           w_nextState;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_rspData;
    logic             r_rspMasked;
    logic [WIDTH-1:0] w_selData;
    logic             w_selMasked;

    tag_mask_sel #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_sel (
        .i_idx      (r_idx),
        .i_tags_vec (io_bus.tags_vec),
        .i_data_vec (io_bus.data_vec),
        .o_data     (w_selData),
        .o_masked   (w_selMasked)
    );

`ifdef TAGGED_READER_SWEEP_EN
    logic [IDXW-1:0] r_sweepIdx;
    logic [IDXW:0]   r_sweepAcc;
    logic [IDXW:0]   r_sweepCnt;
    logic            r_sweepDone;
    logic            w_sweepTag;
    logic            w_sweepLast;

    assign w_sweepTag  = io_bus.tags_vec[r_sweepIdx];
    assign w_sweepLast = (r_sweepIdx == IDXW'(DEPTH - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A request takes priority over a sweep start in IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (io_bus.req_valid) begin
                    w_nextState = LOOKUP;
                end
`ifdef TAGGED_READER_SWEEP_EN
                else if (io_bus.sweep_start) begin
                    w_nextState = SWEEP;
                end
`endif
            end
            LOOKUP: w_nextState = RESP;
            RESP: begin
                if (io_bus.rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
`ifdef TAGGED_READER_SWEEP_EN
            SWEEP: begin
                if (w_sweepLast) begin
                    w_nextState = IDLE;
                end
            end
`endif
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_rspData   <= '0;
            r_rspMasked <= 1'b0;
        end else begin
            if (r_state == IDLE && io_bus.req_valid) begin
                r_idx <= io_bus.req_idx;
            end
            if (r_state == LOOKUP) begin
                r_rspData   <= w_selData;
                r_rspMasked <= w_selMasked;
            end
        end
    end

`ifdef TAGGED_READER_SWEEP_EN
    // One index per cycle; the final count includes the tag of the last index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sweepIdx  <= '0;
            r_sweepAcc  <= '0;
            r_sweepCnt  <= '0;
            r_sweepDone <= 1'b0;
        end else begin
            r_sweepDone <= 1'b0;
            if (r_state == SWEEP) begin
                if (w_sweepLast) begin
                    r_sweepCnt  <= r_sweepAcc + (IDXW+1)'(w_sweepTag);
                    r_sweepDone <= 1'b1;
                    r_sweepIdx  <= '0;
                    r_sweepAcc  <= '0;
                end else begin
                    r_sweepIdx <= r_sweepIdx + IDXW'(1);
                    r_sweepAcc <= r_sweepAcc + (IDXW+1)'(w_sweepTag);
                end
            end
        end
    end

    assign io_bus.sweep_done     = r_sweepDone;
    assign io_bus.sweep_high_cnt = r_sweepCnt;
`endif

    assign io_bus.req_ready  = (r_state == IDLE);
    assign io_bus.rsp_valid  = (r_state == RESP);
    assign io_bus.rsp_data   = r_rspData;
    assign io_bus.rsp_masked = r_rspMasked;

endmodule

// File: tb/tb_tagged_array_reader.sv
// Directed self-checking bench for tagged_array_reader; sweep checks run when
// TAGGED_READER_SWEEP_EN is defined.
module tb_tagged_array_reader;
    localparam int DEPTH = 16;
    localparam int WIDTH = 3;
    localparam int IDXW  = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tagged_array_reader_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .IDXW(IDXW)) bus ();

    tagged_array_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [IDXW-1:0] idx,
                                 input logic ready);
        bus.req_valid = valid;
        bus.req_idx   = idx;
        bus.rsp_ready = ready;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setEntry(input int i, input logic [WIDTH-1:0] v);
        bus.data_vec[i*WIDTH +: WIDTH] = v;
    endtask

    // Handshake in IDLE, expect the response two edges later, accept it.
    task automatic doRead(input string tag, input logic [IDXW-1:0] idx,
                          input logic [WIDTH-1:0] expData, input logic expMasked);
        applyStimulus(1'b1, idx, 1'b1);
        checkOutput({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput({tag, "_lookup_valid"}, 32'(bus.rsp_valid), 32'd0);
        checkOutput({tag, "_lookup_ready"}, 32'(bus.req_ready), 32'd0);
        nextCycle();
        checkOutput({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'(bus.rsp_data), 32'(expData));
        checkOutput({tag, "_masked"}, 32'(bus.rsp_masked), 32'(expMasked));
        nextCycle();
        checkOutput({tag, "_idle"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int hs;
        int rv;
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        bus.tags_vec = '0;
        bus.data_vec = '0;
`ifdef TAGGED_READER_SWEEP_EN
        bus.sweep_start = 1'b0;
`endif
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_data", 32'(bus.rsp_data), 32'd0);
        checkOutput("rst_masked", 32'(bus.rsp_masked), 32'd0);
        checkOutput("rst_ready", 32'(bus.req_ready), 32'd1);
        rst = 1'b0;
        nextCycle();

        // Plain read of a low entry
        setEntry(5, 3'b101);
        doRead("rd5", 4'd5, 3'b101, 1'b0);

        // High entry is masked; later writes to it never show up
        bus.tags_vec[9] = 1'b1;
        setEntry(9, 3'b111);
        applyStimulus(1'b1, 4'd9, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0);
        nextCycle();
        checkOutput("h9_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("h9_data", 32'(bus.rsp_data), 32'd0);
        checkOutput("h9_masked", 32'(bus.rsp_masked), 32'd1);
        setEntry(9, 3'b010);
        nextCycle();
        checkOutput("h9_data_hold", 32'(bus.rsp_data), 32'd0);
        checkOutput("h9_masked_hold", 32'(bus.rsp_masked), 32'd1);
        bus.rsp_ready = 1'b1;
        nextCycle();
        checkOutput("h9_idle", 32'(bus.req_ready), 32'd1);

        // Back-pressure: response held while the array keeps changing
        setEntry(3, 3'b110);
        applyStimulus(1'b1, 4'd3, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0);
        nextCycle();
        for (int k = 0; k < 4; k++) begin
            setEntry(3, 3'(k));
            nextCycle();
            checkOutput("bp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("bp_data", 32'(bus.rsp_data), 32'd6);
            checkOutput("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        nextCycle();
        checkOutput("bp_idle", 32'(bus.req_ready), 32'd1);
        checkOutput("bp_done_valid", 32'(bus.rsp_valid), 32'd0);

        // Writer updates during LOOKUP are the values captured
        setEntry(2, 3'b001);
        applyStimulus(1'b1, 4'd2, 1'b1);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1);
        setEntry(2, 3'b100);
        nextCycle();
        checkOutput("wr_lookup_data", 32'(bus.rsp_data), 32'd4);
        nextCycle();
        setEntry(4, 3'b011);
        applyStimulus(1'b1, 4'd4, 1'b1);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1);
        bus.tags_vec[4] = 1'b1;
        nextCycle();
        checkOutput("tag_lookup_data", 32'(bus.rsp_data), 32'd0);
        checkOutput("tag_lookup_masked", 32'(bus.rsp_masked), 32'd1);
        nextCycle();

        // Requests outside IDLE are neither serviced nor queued
        setEntry(1, 3'b010);
        setEntry(6, 3'b101);
        applyStimulus(1'b1, 4'd1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 4'd6, 1'b0);
        nextCycle();
        checkOutput("ign_data", 32'(bus.rsp_data), 32'd2);
        applyStimulus(1'b0, '0, 1'b1);
        nextCycle();
        checkOutput("ign_idle", 32'(bus.req_ready), 32'd1);
        nextCycle();
        checkOutput("ign_no_queue", 32'(bus.rsp_valid), 32'd0);

        // Back-to-back throughput: one read per three cycles
        hs = 0;
        rv = 0;
        applyStimulus(1'b1, 4'd5, 1'b1);
        for (int k = 0; k < 9; k++) begin
            if (bus.req_valid && bus.req_ready) hs++;
            if (bus.rsp_valid) rv++;
            nextCycle();
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("tp_handshakes", 32'(hs), 32'd3);
        checkOutput("tp_responses", 32'(rv), 32'd3);

        // Reset during LOOKUP drops the response
        applyStimulus(1'b1, 4'd5, 1'b1);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rstmid_data", 32'(bus.rsp_data), 32'd0);
        nextCycle();
        rst = 1'b0;
        checkOutput("rstmid_ready", 32'(bus.req_ready), 32'd1);
        nextCycle();
        checkOutput("rstmid_no_rsp", 32'(bus.rsp_valid), 32'd0);

`ifdef TAGGED_READER_SWEEP_EN
        begin
            int k;
            bit seen;
            bus.tags_vec = 16'hF00F;
            bus.sweep_start = 1'b1;
            nextCycle();
            bus.sweep_start = 1'b0;
            checkOutput("sw_ready", 32'(bus.req_ready), 32'd0);
            k = 0;
            seen = 1'b0;
            while (!seen && k < 40) begin
                if (bus.sweep_done) seen = 1'b1;
                else begin
                    nextCycle();
                    k++;
                end
            end
            checkOutput("sw_latency", 32'(k), 32'd16);
            checkOutput("sw_count", 32'(bus.sweep_high_cnt), 32'd8);
            nextCycle();
            checkOutput("sw_pulse", 32'(bus.sweep_done), 32'd0);
            checkOutput("sw_idle", 32'(bus.req_ready), 32'd1);

            bus.tags_vec = 16'h0001;
            applyStimulus(1'b1, 4'd5, 1'b1);
            bus.sweep_start = 1'b1;
            nextCycle();
            bus.sweep_start = 1'b0;
            applyStimulus(1'b0, '0, 1'b1);
            nextCycle();
            checkOutput("sw_pri_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("sw_pri_data", 32'(bus.rsp_data), 32'd5);
            k = 0;
            for (int c = 0; c < 20; c++) begin
                if (bus.sweep_done) k++;
                nextCycle();
            end
            checkOutput("sw_pri_no_sweep", 32'(k), 32'd0);
            checkOutput("sw_pri_count", 32'(bus.sweep_high_cnt), 32'd8);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tagged_array_reader.md
TAGGED_ARRAY_READER -- requirements
Module: tagged_array_reader

Interface
REQ-001 Parameter DEPTH, 16, number of tagged entries.
REQ-002 Parameter WIDTH, 3, data bits per entry.
REQ-003 Parameter IDXW, 4, index width; SHALL equal clog2(DEPTH).
REQ-004 clk input 1: sole clock, label {L}, all state updates on posedge.
REQ-005 rst input 1: asynchronous, active-high reset, label {L}.
REQ-006 req_valid input 1: read request valid, {L}.
REQ-007 req_idx input IDXW: entry to read, {L}.
REQ-008 req_ready output 1: request accepted when req_valid && req_ready, {L}.
REQ-009 tags_vec input DEPTH: per-entry tag (0 = L, 1 = H), from the writer-side array, {L}.
REQ-010 data_vec input DEPTH*WIDTH: flattened entries (entry i at bits [i*WIDTH +: WIDTH]), each labelled LH by its own tag.
REQ-011 rsp_valid output 1: response valid, {L}.
REQ-012 rsp_ready input 1: response consumer ready, {L}.
REQ-013 rsp_data output WIDTH: returned data, always {L}.
REQ-014 rsp_masked output 1: 1 when the entry was H and data was suppressed, {L}.

Function
REQ-015 FSM states IDLE, LOOKUP, RESP; reset state IDLE.
REQ-016 req_ready SHALL be 1 only in IDLE; handshake in IDLE moves to LOOKUP and registers req_idx.
REQ-017 In LOOKUP, tag and data of the registered index SHALL be captured in the same cycle (atomic snapshot); next state RESP.
REQ-018 Captured tag 0: rsp_data = captured data, rsp_masked = 0; tag 1: rsp_data = 0, rsp_masked = 1.
REQ-019 H data SHALL never reach any output or any {L} register, including intermediate registers.
REQ-020 rsp_valid SHALL be 1 in RESP only; rsp_data/rsp_masked held stable until rsp_valid && rsp_ready, then IDLE.
REQ-021 Latency: request handshake at cycle N -> rsp_valid at N+2; back-to-back throughput one read per 3 cycles with rsp_ready tied high.
REQ-022 Writer updating tags_vec/data_vec in the LOOKUP cycle: the values present on the inputs in that cycle are used; later updates do not alter a held response.
REQ-023 req_valid outside IDLE is ignored and not queued.

Reset
REQ-024 rst SHALL asynchronously force state IDLE, rsp_valid 0, rsp_data 0, rsp_masked 0, registered index 0, and (if enabled) sweep counters 0.
REQ-025 rst asserted mid-transaction SHALL drop the pending response without emitting it; req_ready rises the first cycle after rst deasserts.

Configuration
REQ-026 Macro TAGGED_READER_SWEEP_EN, when defined, adds ports sweep_start (in, 1, {L}), sweep_done (out, 1, {L}), sweep_high_cnt (out, IDXW+1, {L}) and state SWEEP.
REQ-027 With macro: sweep_start in IDLE enters SWEEP; indices 0..DEPTH-1 examined one per cycle, counting tags equal to 1; after index DEPTH-1, sweep_high_cnt updated, one-cycle sweep_done pulse, back to IDLE; req_ready 0 throughout.
REQ-028 With macro: req_valid and sweep_start both high in IDLE -> request wins, sweep_start dropped; sweep_start outside IDLE ignored; index counter SHALL not wrap past DEPTH-1.
REQ-029 Without macro: no sweep ports, no SWEEP state, behaviour per REQ-015..023 only.

Structure
REQ-030 Shared package tagged_array_pkg SHALL hold the FSM state enum, DEPTH/WIDTH/IDXW defaults and tag encoding constants (TAG_L = 0, TAG_H = 1).
REQ-031 One sub-module tag_mask_sel SHALL perform combinational entry select plus masking (index, tags_vec, data_vec -> data, masked); the FSM stays in the top.

Verification
REQ-032 Reset, tags all 0, data[5]=3'b101, read idx 5 -> rsp_valid at cycle N+2, rsp_data=101, rsp_masked=0.
REQ-033 tags[9]=1, data[9]=3'b111, read idx 9 -> rsp_data=000, rsp_masked=1; no other output toggles with data[9].
REQ-034 rsp_ready held 0 for 4 cycles in RESP while data_vec changes -> rsp_data constant; req_ready 0 throughout; IDLE after accept.
REQ-035 rst pulsed during LOOKUP -> no rsp_valid; req_ready=1 first cycle after release.
REQ-036 (SWEEP_EN) tags = 16'hF00F, sweep_start -> sweep_done 16 cycles later, sweep_high_cnt=8; simultaneous req_valid+sweep_start in IDLE -> read serviced, no sweep.
